sram_ctrl: RTL and testbench
============================

# sram_ctrl

Single-port controller for the external 16-bit asynchronous SRAM that backs the frame buffer. It is the responder on the start/rw/addr/data/ready/data_out request interface that the buffer mux forwards from the pixel writer and the pixel reader. It turns each accepted request into a timed read or write cycle on the SRAM pins and returns `ready` plus captured read data.

## Interface
Parameters:
- `WAIT_CYCLES`, 2, number of clock cycles the strobe (`we_n` or read sample window) is held active. Legal range 1..15.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request strobe; sampled only when `ready`=1.
- `rw`  in  1  1 = write, 0 = read.
- `addr`  in  16  word address.
- `data_in`  in  16  write data.
- `ready`  out  1  1 = idle and able to accept a request.
- `data_out`  out  16  last read word.
- `sram_a`  out  16  SRAM address pins.
- `sram_dq_out`  out  16  data driven to SRAM.
- `sram_dq_oe`  out  1  1 = top level enables the `sram_dq` tristate.
- `sram_dq_in`  in  16  data read back from SRAM pins.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`, `sram_ub_n`, `sram_lb_n`  out  1 each  active-low SRAM strobes.

## Operation
- Clocking and reset: one clock; reset is asynchronous and active-low.
- All outputs are registered.
- FSM states: IDLE, SETUP, ACCESS, HOLD.
- IDLE:
  - `ready`=1; all strobes high; `sram_dq_oe`=0.
  - On `start`=1, latch `addr`, `rw` and `data_in` into internal registers, drive `ready`=0, go to SETUP.
- SETUP (1 cycle):
  - `sram_a`=latched address; `ce_n`=`ub_n`=`lb_n`=0.
  - Read: `oe_n`=0.
  - Write: `sram_dq_out`=latched data, `sram_dq_oe`=1, `we_n` stays 1.
  - Clear the wait counter; go to ACCESS.
- ACCESS (`WAIT_CYCLES` cycles):
  - Write: `we_n`=0.
  - Read: `oe_n`=0.
  - The 4-bit counter increments each cycle. When it equals `WAIT_CYCLES`-1, a read loads `sram_dq_in` into `data_out` on that edge; go to HOLD.
- HOLD (1 cycle):
  - `we_n`=1 and `oe_n`=1.
  - `ce_n`, `sram_a` and, for writes, `sram_dq_out`/`sram_dq_oe` are held.
  - This gives address and data hold time after the `we_n` rising edge.
  - Go to IDLE with `ready`=1, all strobes 1, `sram_dq_oe`=0.
- `data_out` changes only on a read capture; writes never alter it.
- `start` while `ready`=0 is ignored; there is no queueing.
- `start` held high in IDLE issues back-to-back transactions, one per `ready` high cycle.
- Request inputs may change freely after acceptance; only the latched copies are used.
- `sram_a` and `sram_dq_out` keep their last values in IDLE; the pin values are don't-care while the strobes are high.

## Timing
- Reset values: `ready`=1, `data_out`=0, `sram_a`=0, `sram_dq_out`=0, `sram_dq_oe`=0, all `_n` strobes=1, state=IDLE, counter=0.
- Reset asserted mid-transaction forces the reset values immediately, without waiting for a clock edge. The transaction is abandoned.
- A request accepted at edge E0 sees:
  - SETUP after E0.
  - ACCESS from E1 to E(`WAIT_CYCLES`+1).
  - HOLD after E(`WAIT_CYCLES`+1).
  - `ready`=1 after E(`WAIT_CYCLES`+2).
- `ready` is low for exactly `WAIT_CYCLES`+2 cycles per transaction.
- Read data is valid on `data_out` no later than the first cycle `ready` returns high. It stays stable until the next read capture.
- Minimum request period is `WAIT_CYCLES`+3 cycles, because the controller spends 1 cycle in IDLE between transactions.
- `sram_dq_oe` and `oe_n`=0 are never both active.
- `we_n` is low only while `ce_n` is low and `sram_dq_oe`=1.

## Test plan
- Reset release, then idle with no `start` -> `ready`=1, `data_out`=0, all strobes 1, `sram_dq_oe`=0 on every cycle.
- Write `addr`=0x1234, `data_in`=0xBEEF, `WAIT_CYCLES`=2:
  - `ready` low exactly 4 cycles.
  - `we_n` low exactly 2 cycles, with `sram_a`=0x1234 and `sram_dq_out`=0xBEEF held from SETUP through HOLD.
  - `oe_n` stays 1.
- Read `addr`=0x1234 with the SRAM model returning 0xBEEF:
  - `oe_n` low for 3 cycles and `sram_dq_oe`=0 throughout.
  - `data_out`=0xBEEF when `ready` rises.
  - A subsequent write leaves `data_out`=0xBEEF.
- `start` held high for 20 cycles, alternating write/read to 0x0000/0xFFFF:
  - A new transaction begins every 5 cycles.
  - Pulses of `start` while `ready`=0 are ignored.
  - Address wrap at 0xFFFF is driven correctly.
- `reset_n` asserted in the 2nd ACCESS cycle of a write:
  - `we_n`, `ce_n` go to 1 and `sram_dq_oe` goes to 0 without waiting for a clock edge.
  - `ready`=1 and `data_out`=0 after release; the next request completes normally.
- `WAIT_CYCLES`=1 and `WAIT_CYCLES`=15 builds -> `ready` low 3 and 17 cycles respectively; read capture is correct in both.

Source files
------------

// File: rtl/sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sram_ctrl
//  Purpose  : Single-port controller for an external 16-bit asynchronous SRAM.
//             Accepts start/rw/addr/data requests while ready is high and runs
//             a timed SETUP -> ACCESS -> HOLD cycle on the SRAM pins. Every
//             output comes straight from a flop.
//  Revision : 1.0  initial release
// ============================================================================
module sram_ctrl #(
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        rw,
   input  logic [15:0] addr,
   input  logic [15:0] data_in,
   output logic        ready,
   output logic [15:0] data_out,
   output logic [15:0] sram_a,
   output logic [15:0] sram_dq_out,
   output logic        sram_dq_oe,
   input  logic [15:0] sram_dq_in,
   output logic        sram_ce_n,
   output logic        sram_oe_n,
   output logic        sram_we_n,
   output logic        sram_ub_n,
   output logic        sram_lb_n
);

   // Counter value on the final ACCESS cycle.
   localparam logic [3:0] C_LAST_CNT = 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_HOLD   = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic [3:0]  r_cnt;
   logic [3:0]  w_cnt_next;

   // Latched copy of the accepted request.
   logic        r_rw;
   logic [15:0] r_addr;
   logic [15:0] r_data;

   // Next values for the registered outputs.
   logic        w_latch;
   logic        w_capture;
   logic        w_ready;
   logic        w_ce_n;
   logic        w_oe_n;
   logic        w_we_n;
   logic        w_bs_n;
   logic        w_dq_oe;
   logic [15:0] w_sram_a;
   logic [15:0] w_dq_out;

   // State register and wait counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_cnt_next;
      end
   end

   // Capture the request on acceptance; later input changes are ignored.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rw   <= 1'b0;
         r_addr <= 16'h0000;
         r_data <= 16'h0000;
      end else if (w_latch) begin
         r_rw   <= rw;
         r_addr <= addr;
         r_data <= data_in;
      end
   end

   // Next-state logic plus the pin values for the state being entered,
   // so the output flops present them exactly in that state.
   always_comb begin
      w_next_state = r_state;
      w_cnt_next   = r_cnt;
      w_latch      = 1'b0;
      w_capture    = 1'b0;
      w_ready      = 1'b1;
      w_ce_n       = 1'b1;
      w_oe_n       = 1'b1;
      w_we_n       = 1'b1;
      w_bs_n       = 1'b1;
      w_dq_oe      = 1'b0;
      w_sram_a     = sram_a;
      w_dq_out     = sram_dq_out;

      case (r_state)
         ST_IDLE: begin
            if (start) begin
               // Entering SETUP: address and chip select, read enables OE
               // early, write puts data on the bus but keeps WE high.
               w_next_state = ST_SETUP;
               w_latch      = 1'b1;
               w_ready      = 1'b0;
               w_ce_n       = 1'b0;
               w_bs_n       = 1'b0;
               w_sram_a     = addr;
               if (rw) begin
                  w_dq_out = data_in;
                  w_dq_oe  = 1'b1;
               end else begin
                  w_oe_n   = 1'b0;
               end
            end
         end

         ST_SETUP: begin
            // Entering ACCESS with a cleared counter.
            w_next_state = ST_ACCESS;
            w_cnt_next   = 4'd0;
            w_ready      = 1'b0;
            w_ce_n       = 1'b0;
            w_bs_n       = 1'b0;
            w_sram_a     = r_addr;
            if (r_rw) begin
               w_dq_out = r_data;
               w_dq_oe  = 1'b1;
               w_we_n   = 1'b0;
            end else begin
               w_oe_n   = 1'b0;
            end
         end

         ST_ACCESS: begin
            w_cnt_next = r_cnt + 4'd1;
            w_ready    = 1'b0;
            w_ce_n     = 1'b0;
            w_bs_n     = 1'b0;
            w_sram_a   = r_addr;
            if (r_rw) begin
               w_dq_out = r_data;
               w_dq_oe  = 1'b1;
            end
            if (r_cnt == C_LAST_CNT) begin
               // Last strobe cycle: sample read data, release WE/OE for HOLD
               // while address, CE and write data stay put.
               w_next_state = ST_HOLD;
               w_capture    = ~r_rw;
            end else if (r_rw) begin
               w_we_n = 1'b0;
            end else begin
               w_oe_n = 1'b0;
            end
         end

         ST_HOLD: begin
            // Back to IDLE: defaults give ready=1 and all strobes inactive.
            w_next_state = ST_IDLE;
         end

         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Output registers; data_out only moves on a read capture.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ready       <= 1'b1;
         data_out    <= 16'h0000;
         sram_a      <= 16'h0000;
         sram_dq_out <= 16'h0000;
         sram_dq_oe  <= 1'b0;
         sram_ce_n   <= 1'b1;
         sram_oe_n   <= 1'b1;
         sram_we_n   <= 1'b1;
         sram_ub_n   <= 1'b1;
         sram_lb_n   <= 1'b1;
      end else begin
         ready       <= w_ready;
         sram_a      <= w_sram_a;
         sram_dq_out <= w_dq_out;
         sram_dq_oe  <= w_dq_oe;
         sram_ce_n   <= w_ce_n;
         sram_oe_n   <= w_oe_n;
         sram_we_n   <= w_we_n;
         sram_ub_n   <= w_bs_n;
         sram_lb_n   <= w_bs_n;
         if (w_capture) begin
            data_out <= sram_dq_in;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_ctrl
//  Purpose  : Self-checking bench for sram_ctrl (WAIT_CYCLES = 2, 1, 15).
//  Revision : 1.0  initial release
// ============================================================================
module tb_sram_ctrl;

   localparam int W = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic        start;
   logic        rw;
   logic [15:0] addr;
   logic [15:0] data_in;
   logic        ready;
   logic [15:0] data_out;
   logic [15:0] sram_a;
   logic [15:0] sram_dq_out;
   logic        sram_dq_oe;
   logic [15:0] sram_dq_in;
   logic        sram_ce_n;
   logic        sram_oe_n;
   logic        sram_we_n;
   logic        sram_ub_n;
   logic        sram_lb_n;

   sram_ctrl #(.WAIT_CYCLES(W)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .rw(rw), .addr(addr),
      .data_in(data_in), .ready(ready), .data_out(data_out), .sram_a(sram_a),
      .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in),
      .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
      .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
   );

   // SRAM model: unwritten words read back as ~address.
   logic [15:0] mem [65536];
   logic        mem_init = 1'b0;
   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 65536; i++) mem[i] <= ~i[15:0];
         mem_init <= 1'b1;
      end else if (!sram_we_n && !sram_ce_n) begin
         mem[sram_a] <= sram_dq_out;
      end
   end
   assign sram_dq_in = !sram_oe_n ? mem[sram_a] : 16'h0000;

   // Two extra builds: index 0 -> WAIT_CYCLES=1, index 1 -> WAIT_CYCLES=15.
   logic        s_start;
   logic        s_rw;
   logic [15:0] s_addr;
   logic [15:0] s_data;
   logic [1:0]  s_ready, s_dq_oe, s_ce_n, s_oe_n, s_we_n, s_ub_n, s_lb_n;
   logic [15:0] s_dout [2];
   logic [15:0] s_a [2];
   logic [15:0] s_dq_out [2];
   logic [15:0] s_dq_in [2];

   assign s_dq_in[0] = !s_oe_n[0] ? ~s_a[0] : 16'h0000;
   assign s_dq_in[1] = !s_oe_n[1] ? ~s_a[1] : 16'h0000;

   sram_ctrl #(.WAIT_CYCLES(1)) dut_w1 (
      .clk(clk), .reset_n(reset_n), .start(s_start), .rw(s_rw), .addr(s_addr),
      .data_in(s_data), .ready(s_ready[0]), .data_out(s_dout[0]), .sram_a(s_a[0]),
      .sram_dq_out(s_dq_out[0]), .sram_dq_oe(s_dq_oe[0]), .sram_dq_in(s_dq_in[0]),
      .sram_ce_n(s_ce_n[0]), .sram_oe_n(s_oe_n[0]), .sram_we_n(s_we_n[0]),
      .sram_ub_n(s_ub_n[0]), .sram_lb_n(s_lb_n[0])
   );

   sram_ctrl #(.WAIT_CYCLES(15)) dut_w15 (
      .clk(clk), .reset_n(reset_n), .start(s_start), .rw(s_rw), .addr(s_addr),
      .data_in(s_data), .ready(s_ready[1]), .data_out(s_dout[1]), .sram_a(s_a[1]),
      .sram_dq_out(s_dq_out[1]), .sram_dq_oe(s_dq_oe[1]), .sram_dq_in(s_dq_in[1]),
      .sram_ce_n(s_ce_n[1]), .sram_oe_n(s_oe_n[1]), .sram_we_n(s_we_n[1]),
      .sram_ub_n(s_ub_n[1]), .sram_lb_n(s_lb_n[1])
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   typedef struct {
      logic        rw;
      logic [15:0] addr;
      logic [15:0] din;
      logic [15:0] exp_dout;
   } vec_t;

   // One transaction on the W=2 DUT; entered and left at a negedge with ready=1.
   task automatic run_txn(input logic t_rw, input logic [15:0] t_a, input logic [15:0] t_d,
                          input logic [15:0] t_exp, input string tag);
      int busy, we_lo, oe_lo, a_bad, d_bad, inv_bad;
      busy = 0; we_lo = 0; oe_lo = 0; a_bad = 0; d_bad = 0; inv_bad = 0;
      chk({tag, "_ready_before"}, 32'(ready), 32'd1);
      start = 1'b1; rw = t_rw; addr = t_a; data_in = t_d;
      @(negedge clk);
      start = 1'b0; rw = ~t_rw; addr = ~t_a; data_in = ~t_d;
      while (!ready && busy < 40) begin
         busy++;
         if (!sram_we_n) we_lo++;
         if (!sram_oe_n) oe_lo++;
         if (sram_a != t_a || sram_ce_n || sram_ub_n || sram_lb_n) a_bad++;
         if (t_rw && (sram_dq_out != t_d || !sram_dq_oe)) d_bad++;
         if (!t_rw && sram_dq_oe) d_bad++;
         if (!sram_oe_n && sram_dq_oe) inv_bad++;
         if (!sram_we_n && (sram_ce_n || !sram_dq_oe)) inv_bad++;
         @(negedge clk);
      end
      chk({tag, "_ready_low"}, busy, W + 2);
      chk({tag, "_we_low"}, we_lo, t_rw ? W : 0);
      chk({tag, "_oe_low"}, oe_lo, t_rw ? 0 : W + 1);
      chk({tag, "_addr_hold"}, a_bad, 0);
      chk({tag, "_dq_bus"}, d_bad, 0);
      chk({tag, "_strobe_rules"}, inv_bad, 0);
      chk({tag, "_data_out"}, 32'(data_out), 32'(t_exp));
      chk({tag, "_idle_pins"},
          32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe}), 32'h3E);
   endtask

   // One transaction on both extra builds at once.
   task automatic run_s_txn(input logic t_rw, input logic [15:0] t_a, input logic [15:0] t_d,
                            input logic [15:0] t_exp, input string tag);
      int cnt [2];
      int bad;
      cnt[0] = 0; cnt[1] = 0; bad = 0;
      chk({tag, "_ready_before"}, 32'(s_ready), 32'd3);
      s_start = 1'b1; s_rw = t_rw; s_addr = t_a; s_data = t_d;
      @(negedge clk);
      s_start = 1'b0; s_addr = ~t_a; s_data = ~t_d;
      for (int c = 0; c < 30; c++) begin
         for (int j = 0; j < 2; j++) begin
            if (!s_ready[j]) begin
               cnt[j]++;
               if (s_ce_n[j] || s_ub_n[j] || s_lb_n[j] || s_a[j] != t_a) bad++;
            end
            if (!s_oe_n[j] && s_dq_oe[j]) bad++;
            if (!s_we_n[j] && (s_ce_n[j] || !s_dq_oe[j] || s_dq_out[j] != t_d)) bad++;
         end
         @(negedge clk);
      end
      chk({tag, "_w1_ready_low"}, cnt[0], 3);
      chk({tag, "_w15_ready_low"}, cnt[1], 17);
      chk({tag, "_pin_rules"}, bad, 0);
      chk({tag, "_w1_data_out"}, 32'(s_dout[0]), 32'(t_exp));
      chk({tag, "_w15_data_out"}, 32'(s_dout[1]), 32'(t_exp));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [7];
      vec_t bb [4];
      int   idle_bad, k, last, gap_bad, a_bad, rd_bad, wait_c;

      vecs[0] = '{1'b1, 16'h1234, 16'hBEEF, 16'h0000};
      vecs[1] = '{1'b0, 16'h1234, 16'h0000, 16'hBEEF};
      vecs[2] = '{1'b1, 16'h0001, 16'h0042, 16'hBEEF};
      vecs[3] = '{1'b0, 16'h0001, 16'h0000, 16'h0042};
      vecs[4] = '{1'b0, 16'h7777, 16'h0000, 16'h8888};
      vecs[5] = '{1'b1, 16'hFFFF, 16'h8001, 16'h8888};
      vecs[6] = '{1'b0, 16'hFFFF, 16'h0000, 16'h8001};

      bb[0] = '{1'b1, 16'hFFFF, 16'hA5A5, 16'h0000};
      bb[1] = '{1'b0, 16'hFFFF, 16'h0000, 16'hA5A5};
      bb[2] = '{1'b1, 16'h0000, 16'h5A5A, 16'h0000};
      bb[3] = '{1'b0, 16'h0000, 16'h0000, 16'h5A5A};

      reset_n = 1'b0; start = 1'b0; rw = 1'b0; addr = 16'h0; data_in = 16'h0;
      s_start = 1'b0; s_rw = 1'b0; s_addr = 16'h0; s_data = 16'h0;
      repeat (3) @(negedge clk);

      // Reset values.
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_data_out", 32'(data_out), 32'd0);
      chk("rst_sram_a", 32'(sram_a), 32'd0);
      chk("rst_dq_out", 32'(sram_dq_out), 32'd0);
      chk("rst_pins",
          32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe}), 32'h3E);

      reset_n = 1'b1;
      idle_bad = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (!ready || data_out != 16'h0 || !sram_ce_n || !sram_oe_n || !sram_we_n ||
             !sram_ub_n || !sram_lb_n || sram_dq_oe) idle_bad++;
      end
      chk("idle_after_reset", idle_bad, 0);

      // Directed vector table.
      for (int i = 0; i < 7; i++)
         run_txn(vecs[i].rw, vecs[i].addr, vecs[i].din, vecs[i].exp_dout, $sformatf("v%0d", i));

      // start held high for 20 cycles, alternating write/read at 0xFFFF and 0x0000.
      k = 0; last = 0; gap_bad = 0; a_bad = 0; rd_bad = 0;
      start = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (k > 0 && c == last + 1 && sram_a != bb[k - 1].addr) a_bad++;
         if (ready) begin
            if (k > 0) begin
               if (c - last != W + 3) gap_bad++;
               if (!bb[k - 1].rw && data_out != bb[k - 1].exp_dout) rd_bad++;
            end
            last = c;
            rw = bb[k % 4].rw; addr = bb[k % 4].addr; data_in = bb[k % 4].din;
            k++;
         end else begin
            rw = ~rw; addr = 16'h5555; data_in = 16'h3333;
         end
         @(negedge clk);
      end
      start = 1'b0;
      wait_c = 0;
      while (!ready && wait_c < 20) begin
         wait_c++;
         @(negedge clk);
      end
      chk("b2b_accepts", k, 4);
      chk("b2b_period", gap_bad, 0);
      chk("b2b_setup_addr", a_bad, 0);
      chk("b2b_read_data", rd_bad, 0);
      chk("b2b_final_data_out", 32'(data_out), 32'h5A5A);

      // Reset in the second ACCESS cycle of a write.
      @(negedge clk);
      start = 1'b1; rw = 1'b1; addr = 16'h2222; data_in = 16'h1111;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("arst_we_active", 32'(sram_we_n), 32'd0);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_pins",
          32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe}), 32'h3E);
      chk("arst_ready", 32'(ready), 32'd1);
      chk("arst_data_out", 32'(data_out), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("arst_release_ready", 32'(ready), 32'd1);
      chk("arst_release_data_out", 32'(data_out), 32'd0);
      run_txn(1'b0, 16'h1234, 16'h0000, 16'hBEEF, "post_rst");

      // WAIT_CYCLES = 1 and 15 builds.
      run_s_txn(1'b0, 16'h0F0F, 16'h0000, 16'hF0F0, "s_rd0");
      run_s_txn(1'b1, 16'h1111, 16'h3C3C, 16'hF0F0, "s_wr");
      run_s_txn(1'b0, 16'hFFFF, 16'h0000, 16'h0000, "s_rd1");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
